cdb_arbiter: RTL and testbench

- Shares a single common data bus (CDB) between the execute-stage and memory-stage result producers.
- Each producer pushes results (phys-reg map, value, instr number) into a small per-source FIFO.
- The arbiter drains one result per cycle onto a registered CDB. The issue queue, physreg file and ROB consume the CDB as their only wakeup/writeback broadcast.
- Replaces the dual exe/mem broadcast ports with one ordered, backpressured broadcast.

---
 rtl/cdb_arbiter_if.sv | 46 ++++
 rtl/cdb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-producer / common-data-bus bundle for cdb_arbiter: exe and mem result
// offers with their ready flags, the registered CDB broadcast and FIFO occupancies.
interface cdb_arbiter_if #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              exe_valid;
   logic              exe_ready;
   logic [TAG_W-1:0]  exe_map;
   logic [DATA_W-1:0] exe_val;
   logic [31:0]       exe_instr_num;

   logic              mem_valid;
   logic              mem_ready;
   logic [TAG_W-1:0]  mem_map;
   logic [DATA_W-1:0] mem_val;
   logic [31:0]       mem_instr_num;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_map;
   logic [DATA_W-1:0] cdb_val;
   logic [31:0]       cdb_instr_num;
   logic              cdb_src;

   logic [CNT_W-1:0]  exe_count;
   logic [CNT_W-1:0]  mem_count;

   modport master (
      output exe_valid, exe_map, exe_val, exe_instr_num,
      output mem_valid, mem_map, mem_val, mem_instr_num,
      input  exe_ready, mem_ready,
      input  cdb_valid, cdb_map, cdb_val, cdb_instr_num, cdb_src,
      input  exe_count, mem_count
   );

   modport slave (
      input  exe_valid, exe_map, exe_val, exe_instr_num,
      input  mem_valid, mem_map, mem_val, mem_instr_num,
      output exe_ready, mem_ready,
      output cdb_valid, cdb_map, cdb_val, cdb_instr_num, cdb_src,
      output exe_count, mem_count
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-source result FIFOs draining one entry per cycle onto a registered CDB.
// Default: mem-first with an exe starvation override; define CDB_AGE_PRIORITY_EN for oldest-first.
module cdb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int TAG_W      = 6,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         FLUSH,
   cdb_arbiter_if.slave bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int SRC_EXE = 0;
   localparam int SRC_MEM = 1;

   typedef struct packed {
      logic [TAG_W-1:0]  map;
      logic [DATA_W-1:0] val;
      logic [31:0]       instr_num;
   } entry_t;

   entry_t           fifo_q     [2][DEPTH];
   entry_t           fifo_d     [2][DEPTH];
   logic [PTR_W-1:0] wr_ptr_q   [2];
   logic [PTR_W-1:0] wr_ptr_d   [2];
   logic [PTR_W-1:0] rd_ptr_q   [2];
   logic [PTR_W-1:0] rd_ptr_d   [2];
   logic [CNT_W-1:0] cnt_q      [2];
   logic [CNT_W-1:0] cnt_d      [2];
   logic             ready_q    [2];
   logic             ready_d    [2];

   logic             cdb_valid_q;
   logic             cdb_valid_d;
   logic             cdb_src_q;
   logic             cdb_src_d;
   entry_t           cdb_entry_q;
   entry_t           cdb_entry_d;

   logic             in_valid_s [2];
   entry_t           in_entry_s [2];
   entry_t           head_s     [2];
   logic             nonempty_s [2];
   logic             push_s     [2];
   logic             store_s    [2];
   logic             pop_s      [2];
   logic             grant_mem_s;

`ifndef CDB_AGE_PRIORITY_EN
   localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   logic [STARVE_W-1:0] starve_q;
   logic [STARVE_W-1:0] starve_d;
`endif

   // Gather both producers into source-indexed arrays and expose the FIFO heads.
   always_comb begin
      in_valid_s[SRC_EXE] = bus.exe_valid;
      in_entry_s[SRC_EXE] = {bus.exe_map, bus.exe_val, bus.exe_instr_num};
      in_valid_s[SRC_MEM] = bus.mem_valid;
      in_entry_s[SRC_MEM] = {bus.mem_map, bus.mem_val, bus.mem_instr_num};
      for (int s = 0; s < 2; s++) begin
         head_s[s]     = fifo_q[s][rd_ptr_q[s]];
         nonempty_s[s] = (cnt_q[s] != '0);
      end
   end

   // Pick which head goes onto the CDB this cycle; only state at the start of the cycle is used.
   always_comb begin
      grant_mem_s = 1'b0;
      if (nonempty_s[SRC_EXE] && nonempty_s[SRC_MEM]) begin
`ifdef CDB_AGE_PRIORITY_EN
         grant_mem_s = !(head_s[SRC_EXE].instr_num < head_s[SRC_MEM].instr_num);
`else
         grant_mem_s = (starve_q != STARVE_W'(STARVE_MAX));
`endif
      end else if (nonempty_s[SRC_MEM]) begin
         grant_mem_s = 1'b1;
      end else begin
         grant_mem_s = 1'b0;
      end
      pop_s[SRC_EXE] = nonempty_s[SRC_EXE] && !grant_mem_s;
      pop_s[SRC_MEM] = nonempty_s[SRC_MEM] && grant_mem_s;
   end

   // Next-state for FIFOs, CDB registers and starvation counter; FLUSH overrides everything.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         fifo_d[s]   = fifo_q[s];
         wr_ptr_d[s] = wr_ptr_q[s];
         rd_ptr_d[s] = rd_ptr_q[s];
         cnt_d[s]    = cnt_q[s];
         ready_d[s]  = ready_q[s];
         push_s[s]   = in_valid_s[s] && ready_q[s];
         // Tag 0 is the null register: complete the handshake but drop the result.
         store_s[s]  = push_s[s] && (in_entry_s[s].map != '0);
      end
      cdb_valid_d = 1'b0;
      cdb_src_d   = cdb_src_q;
      cdb_entry_d = cdb_entry_q;
`ifndef CDB_AGE_PRIORITY_EN
      starve_d    = starve_q;
`endif

      if (FLUSH) begin
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
               fifo_d[s][i] = '0;
            end
            wr_ptr_d[s] = '0;
            rd_ptr_d[s] = '0;
            cnt_d[s]    = '0;
            ready_d[s]  = 1'b1;
         end
         cdb_valid_d = 1'b0;
         cdb_src_d   = 1'b0;
         cdb_entry_d = '0;
`ifndef CDB_AGE_PRIORITY_EN
         starve_d    = '0;
`endif
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (store_s[s]) begin
               fifo_d[s][wr_ptr_q[s]] = in_entry_s[s];
               wr_ptr_d[s]            = wr_ptr_q[s] + PTR_W'(1);
            end else begin
               wr_ptr_d[s] = wr_ptr_q[s];
            end
            if (pop_s[s]) begin
               rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
            end else begin
               rd_ptr_d[s] = rd_ptr_q[s];
            end
            cnt_d[s]   = cnt_q[s] + CNT_W'(store_s[s]) - CNT_W'(pop_s[s]);
            ready_d[s] = (cnt_d[s] != CNT_W'(DEPTH));
         end

         cdb_valid_d = pop_s[SRC_EXE] || pop_s[SRC_MEM];
         if (pop_s[SRC_MEM]) begin
            cdb_entry_d = head_s[SRC_MEM];
            cdb_src_d   = 1'b1;
         end else if (pop_s[SRC_EXE]) begin
            cdb_entry_d = head_s[SRC_EXE];
            cdb_src_d   = 1'b0;
         end else begin
            cdb_entry_d = cdb_entry_q;
            cdb_src_d   = cdb_src_q;
         end

`ifndef CDB_AGE_PRIORITY_EN
         if (!nonempty_s[SRC_EXE] || pop_s[SRC_EXE]) begin
            starve_d = '0;
         end else begin
            starve_d = starve_q + STARVE_W'(1);
         end
`endif
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
               fifo_q[s][i] <= '0;
            end
            wr_ptr_q[s] <= '0;
            rd_ptr_q[s] <= '0;
            cnt_q[s]    <= '0;
            ready_q[s]  <= 1'b1;
         end
         cdb_valid_q <= 1'b0;
         cdb_src_q   <= 1'b0;
         cdb_entry_q <= '0;
`ifndef CDB_AGE_PRIORITY_EN
         starve_q    <= '0;
`endif
      end else begin
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
               fifo_q[s][i] <= fifo_d[s][i];
            end
            wr_ptr_q[s] <= wr_ptr_d[s];
            rd_ptr_q[s] <= rd_ptr_d[s];
            cnt_q[s]    <= cnt_d[s];
            ready_q[s]  <= ready_d[s];
         end
         cdb_valid_q <= cdb_valid_d;
         cdb_src_q   <= cdb_src_d;
         cdb_entry_q <= cdb_entry_d;
`ifndef CDB_AGE_PRIORITY_EN
         starve_q    <= starve_d;
`endif
      end
   end

   assign bus.exe_ready     = ready_q[SRC_EXE];
   assign bus.mem_ready     = ready_q[SRC_MEM];
   assign bus.exe_count     = cnt_q[SRC_EXE];
   assign bus.mem_count     = cnt_q[SRC_MEM];
   assign bus.cdb_valid     = cdb_valid_q;
   assign bus.cdb_src       = cdb_src_q;
   assign bus.cdb_map       = cdb_entry_q.map;
   assign bus.cdb_val       = cdb_entry_q.val;
   assign bus.cdb_instr_num = cdb_entry_q.instr_num;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_cdb_arbiter;
   localparam int DEPTH      = 4;
   localparam int TAG_W      = 6;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 3;

   logic CLK = 1'b0;
   logic RESET;
   logic FLUSH;
   int   n_vec = 0;
   int   n_bad = 0;

   cdb_arbiter_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   cdb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .FLUSH (FLUSH),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [TAG_W-1:0]  map;
      logic [DATA_W-1:0] val;
      logic [31:0]       num;
   } ent_t;

   typedef struct {
      logic              src;
      logic [TAG_W-1:0]  map;
      logic [DATA_W-1:0] val;
   } bc_t;

   ent_t qe[$];
   ent_t qm[$];
   bc_t  blog[$];
   int   starve = 0;
   logic              m_valid = 1'b0;
   logic              m_src   = 1'b0;
   logic [TAG_W-1:0]  m_map   = '0;
   logic [DATA_W-1:0] m_val   = '0;
   logic [31:0]       m_num   = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: per-source queues, mem-first (or oldest-first) selection, compare after each edge.
   always @(posedge CLK) begin
      ent_t pe;
      ent_t pm;
      int   ne;
      int   nm;
      bit   e_acc;
      bit   m_acc;
      bit   take_mem;
      pe = '{bus.exe_map, bus.exe_val, bus.exe_instr_num};
      pm = '{bus.mem_map, bus.mem_val, bus.mem_instr_num};
      if (!RESET || FLUSH) begin
         qe.delete();
         qm.delete();
         starve  = 0;
         m_valid = 1'b0;
         m_src   = 1'b0;
         m_map   = '0;
         m_val   = '0;
         m_num   = '0;
      end else begin
         ne    = qe.size();
         nm    = qm.size();
         e_acc = bus.exe_valid && (ne < DEPTH);
         m_acc = bus.mem_valid && (nm < DEPTH);
         m_valid = (ne > 0) || (nm > 0);
         if (m_valid) begin
            if (ne > 0 && nm > 0) begin
`ifdef CDB_AGE_PRIORITY_EN
               take_mem = !(qe[0].num < qm[0].num);
`else
               take_mem = (starve < STARVE_MAX);
`endif
            end else begin
               take_mem = (nm > 0);
            end
            if (take_mem) begin
               m_src = 1'b1; m_map = qm[0].map; m_val = qm[0].val; m_num = qm[0].num;
               void'(qm.pop_front());
               starve = (ne > 0) ? starve + 1 : 0;
            end else begin
               m_src = 1'b0; m_map = qe[0].map; m_val = qe[0].val; m_num = qe[0].num;
               void'(qe.pop_front());
               starve = 0;
            end
         end else begin
            starve = 0;
         end
         if (e_acc && pe.map != '0) qe.push_back(pe);
         if (m_acc && pm.map != '0) qm.push_back(pm);
      end
      #1;
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
      chk("cdb_src", 64'(bus.cdb_src), 64'(m_src));
      chk("cdb_map", 64'(bus.cdb_map), 64'(m_map));
      chk("cdb_val", 64'(bus.cdb_val), 64'(m_val));
      chk("cdb_instr_num", 64'(bus.cdb_instr_num), 64'(m_num));
      chk("exe_count", 64'(bus.exe_count), 64'(qe.size()));
      chk("mem_count", 64'(bus.mem_count), 64'(qm.size()));
      chk("exe_ready", 64'(bus.exe_ready), 64'(qe.size() < DEPTH));
      chk("mem_ready", 64'(bus.mem_ready), 64'(qm.size() < DEPTH));
      if (bus.cdb_valid) blog.push_back('{bus.cdb_src, bus.cdb_map, bus.cdb_val});
   end

   task automatic cyc(input bit ev, input int em, input int ex, input int ei,
                      input bit mv, input int mm, input int mx, input int mi);
      bus.exe_valid = ev; bus.exe_map = TAG_W'(em); bus.exe_val = DATA_W'(ex); bus.exe_instr_num = 32'(ei);
      bus.mem_valid = mv; bus.mem_map = TAG_W'(mm); bus.mem_val = DATA_W'(mx); bus.mem_instr_num = 32'(mi);
      @(negedge CLK);
      bus.exe_valid = 1'b0;
      bus.mem_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int exp3[8];
      int first6[2];
      int sent;
      int held;
      int k;
      bit acc;
      bit saw4;
`ifdef CDB_AGE_PRIORITY_EN
      exp3   = '{0, 0, 0, 0, 1, 1, 1, 1};
      first6 = '{0, 1};
`else
      exp3   = '{1, 1, 1, 0, 1, 0, 0, 0};
      first6 = '{1, 0};
`endif
      RESET = 1'b0;
      FLUSH = 1'b0;
      bus.exe_valid = 1'b0; bus.exe_map = '0; bus.exe_val = '0; bus.exe_instr_num = '0;
      bus.mem_valid = 1'b0; bus.mem_map = '0; bus.mem_val = '0; bus.mem_instr_num = '0;
      repeat (2) @(negedge CLK);
      chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      chk("rst_exe_ready", 64'(bus.exe_ready), 64'd1);
      RESET = 1'b1;

      // Reset/FLUSH: two accepted entries are wiped by FLUSH before broadcast
      blog.delete();
      cyc(1'b1, 5, 'hAA, 1, 1'b1, 9, 'hBB, 2);
      chk("t1_exe_cnt_pre", 64'(bus.exe_count), 64'd1);
      chk("t1_mem_cnt_pre", 64'(bus.mem_count), 64'd1);
      FLUSH = 1'b1;
      @(negedge CLK);
      FLUSH = 1'b0;
      chk("t1_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      chk("t1_exe_count", 64'(bus.exe_count), 64'd0);
      chk("t1_mem_count", 64'(bus.mem_count), 64'd0);
      chk("t1_exe_ready", 64'(bus.exe_ready), 64'd1);
      chk("t1_mem_ready", 64'(bus.mem_ready), 64'd1);
      chk("t1_no_bcast", 64'(blog.size()), 64'd0);

      // Single-source latency
      cyc(1'b1, 7, 'h1234, 3, 1'b0, 0, 0, 0);
      chk("t2_no_bypass", 64'(bus.cdb_valid), 64'd0);
      @(negedge CLK);
      chk("t2_valid", 64'(bus.cdb_valid), 64'd1);
      chk("t2_map", 64'(bus.cdb_map), 64'd7);
      chk("t2_val", 64'(bus.cdb_val), 64'h1234);
      chk("t2_instr", 64'(bus.cdb_instr_num), 64'd3);
      chk("t2_src", 64'(bus.cdb_src), 64'd0);
      @(negedge CLK);
      chk("t2_valid_off", 64'(bus.cdb_valid), 64'd0);

      // Priority and starvation: both sources pushed four times back to back
      blog.delete();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1 + i, 'h100 + i, 100 + i, 1'b1, 10 + i, 'h200 + i, 200 + i);
      repeat (8) @(negedge CLK);
      chk("t3_count", 64'(blog.size()), 64'd8);
      for (int i = 0; i < 8 && i < blog.size(); i++) chk($sformatf("t3_src%0d", i), 64'(blog[i].src), 64'(exp3[i]));

      // Full backpressure on exe while mem keeps pushing
      blog.delete();
      sent = 0; held = 0; saw4 = 1'b0;
      for (int c = 0; c < 40 && (sent < 5 || c < 8); c++) begin
         bus.mem_valid = (c < 8); bus.mem_map = TAG_W'(30 + c); bus.mem_val = DATA_W'('h600 + c); bus.mem_instr_num = 32'(10 + c);
         bus.exe_valid = (sent < 5); bus.exe_map = TAG_W'(20 + sent); bus.exe_val = DATA_W'('h500 + sent); bus.exe_instr_num = 32'(1000 + sent);
         if (sent == 4 && !saw4) begin
            saw4 = 1'b1;
            chk("t4_ready_full", 64'(bus.exe_ready), 64'd0);
         end
         acc = bus.exe_valid && bus.exe_ready;
         if (bus.exe_valid && !bus.exe_ready) held++;
         @(negedge CLK);
         if (acc) sent++;
      end
      bus.exe_valid = 1'b0;
      bus.mem_valid = 1'b0;
      chk("t4_all_accepted", 64'(sent), 64'd5);
      chk("t4_held", 64'(held > 0), 64'd1);
      repeat (20) @(negedge CLK);
      k = 0;
      foreach (blog[i]) begin
         if (blog[i].src == 1'b0) begin
            chk($sformatf("t4_order%0d", k), 64'(blog[i].val), 64'('h500 + k));
            k++;
         end
      end
      chk("t4_exe_total", 64'(k), 64'd5);

      // Map 0 is accepted but never stored or broadcast
      blog.delete();
      cyc(1'b0, 0, 0, 0, 1'b1, 0, 'hFF, 50);
      chk("t5_cnt_after_map0", 64'(bus.mem_count), 64'd0);
      cyc(1'b0, 0, 0, 0, 1'b1, 4, 'h10, 51);
      chk("t5_cnt_after_map4", 64'(bus.mem_count), 64'd1);
      @(negedge CLK);
      chk("t5_cnt_drained", 64'(bus.mem_count), 64'd0);
      repeat (2) @(negedge CLK);
      chk("t5_bcast_count", 64'(blog.size()), 64'd1);
      if (blog.size() > 0) begin
         chk("t5_map", 64'(blog[0].map), 64'd4);
         chk("t5_val", 64'(blog[0].val), 64'h10);
      end

      // Age ordering: 12 vs 20, then a 15/15 tie
      blog.delete();
      cyc(1'b1, 11, 'hC, 12, 1'b1, 12, 'hD, 20);
      repeat (4) @(negedge CLK);
      chk("t6_count", 64'(blog.size()), 64'd2);
      for (int i = 0; i < 2 && i < blog.size(); i++) chk($sformatf("t6_src%0d", i), 64'(blog[i].src), 64'(first6[i]));
      blog.delete();
      cyc(1'b1, 13, 'hE, 15, 1'b1, 14, 'hF, 15);
      repeat (4) @(negedge CLK);
      chk("t6_tie_count", 64'(blog.size()), 64'd2);
      if (blog.size() == 2) begin
         chk("t6_tie_first", 64'(blog[0].src), 64'd1);
         chk("t6_tie_second", 64'(blog[1].src), 64'd0);
      end

      // Asynchronous reset with an entry pending
      cyc(1'b1, 33, 'h77, 60, 1'b0, 0, 0, 0);
      RESET = 1'b0;
      #1;
      chk("t7_async_count", 64'(bus.exe_count), 64'd0);
      chk("t7_async_ready", 64'(bus.exe_ready), 64'd1);
      @(negedge CLK);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      chk("t7_no_bcast", 64'(bus.cdb_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
